// File: rtl/rv_decode_pkg.sv
// Shared types and constants for the registered RV32I decode queue.
package rv_decode_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef enum logic [2:0] {
      ITYPE_R   = 3'd0,
      ITYPE_I   = 3'd1,
      ITYPE_U   = 3'd2,
      ITYPE_CSR = 3'd3,
      ITYPE_ILL = 3'd7
   } itype_e;

   typedef enum logic [3:0] {
      INSTR_AND   = 4'b0000,
      INSTR_OR    = 4'b0001,
      INSTR_XOR   = 4'b0010,
      INSTR_ADD   = 4'b0011,
      INSTR_SUB   = 4'b0100,
      INSTR_SLL   = 4'b0101,
      INSTR_SRL   = 4'b0110,
      INSTR_SRA   = 4'b0111,
      INSTR_SLT   = 4'b1000,
      INSTR_SLTU  = 4'b1001,
      INSTR_LUI   = 4'b1010,
      INSTR_CSRRW = 4'b1011,
      INSTR_CSRRS = 4'b1100,
      INSTR_CSRRC = 4'b1101
   } instr_e;

   // Every decoded field except the XLEN-wide immediate, which is attached
   // by the modules that know XLEN (see decoded_t in the top).
   typedef struct packed {
      logic [6:0]  opcode;
      logic [6:0]  funct7;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [11:0] csr;
      itype_e      itype;
      instr_e      instr;
      logic        illegal;
   } decoded_fields_t;

   // ALU operation selected by funct3 when funct7 is all zero.
   function automatic instr_e base_alu_op(input logic [2:0] f3);
      instr_e op;
      case (f3)
         3'b000:  op = INSTR_ADD;
         3'b001:  op = INSTR_SLL;
         3'b010:  op = INSTR_SLT;
         3'b011:  op = INSTR_SLTU;
         3'b100:  op = INSTR_XOR;
         3'b101:  op = INSTR_SRL;
         3'b110:  op = INSTR_OR;
         3'b111:  op = INSTR_AND;
         default: op = INSTR_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv_decode_queue_if.sv
// Input/output handshake bundle of the decode queue.
interface rv_decode_queue_if
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [6:0]      opcode;
   logic [6:0]      funct7;
   logic [2:0]      funct3;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [4:0]      rd;
   logic [4:0]      shamt;
   logic [11:0]     csr;
   itype_e          itype;
   instr_e          instr;
   logic [XLEN-1:0] imm;
   logic            illegal;

   // Instruction source and decoded-entry consumer side.
   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, opcode, funct7, funct3, rs1, rs2, rd,
             shamt, csr, itype, instr, imm, illegal
   );

   // Decode queue side.
   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, opcode, funct7, funct3, rs1, rs2, rd,
             shamt, csr, itype, instr, imm, illegal
   );
endinterface

// File: rtl/rv_decode_comb.sv
// Purely combinational RV32I decoder: raw word in, decoded record out.
module rv_decode_comb
   import rv_decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   output decoded_fields_t fields_o,
   output logic [XLEN-1:0] imm_o
);

   logic [6:0]         opcode_s;
   logic [6:0]         funct7_s;
   logic [2:0]         funct3_s;
   itype_e             itype_s;
   instr_e             op_s;
   logic signed [31:0] imm32_s;

   assign opcode_s = instr_i[6:0];
   assign funct7_s = instr_i[31:25];
   assign funct3_s = instr_i[14:12];

   // Classify the word, pick the ALU operation and form a 32-bit immediate.
   always_comb begin
      itype_s = ITYPE_ILL;
      op_s    = INSTR_AND;
      imm32_s = 32'sd0;
      case (opcode_s)
         OPC_R: begin
            if (funct7_s == F7_ZERO) begin
               itype_s = ITYPE_R;
               op_s    = base_alu_op(funct3_s);
            end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b000)) begin
               itype_s = ITYPE_R;
               op_s    = INSTR_SUB;
            end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b101)) begin
               itype_s = ITYPE_R;
               op_s    = INSTR_SRA;
            end else begin
               itype_s = ITYPE_ILL;
            end
         end
         OPC_I: begin
            imm32_s = {{20{instr_i[31]}}, instr_i[31:20]};
            case (funct3_s)
               3'b001: begin
                  // Only the shift-immediates constrain the upper bits.
                  if (funct7_s == F7_ZERO) begin
                     itype_s = ITYPE_I;
                     op_s    = INSTR_SLL;
                  end else begin
                     itype_s = ITYPE_ILL;
                  end
               end
               3'b101: begin
                  if (funct7_s == F7_ZERO) begin
                     itype_s = ITYPE_I;
                     op_s    = INSTR_SRL;
                  end else if (funct7_s == F7_ALT) begin
                     itype_s = ITYPE_I;
                     op_s    = INSTR_SRA;
                  end else begin
                     itype_s = ITYPE_ILL;
                  end
               end
               default: begin
                  // funct3 000 is ADDI; there is no immediate subtract.
                  itype_s = ITYPE_I;
                  op_s    = base_alu_op(funct3_s);
               end
            endcase
         end
         OPC_LUI: begin
            itype_s = ITYPE_U;
            op_s    = INSTR_LUI;
            imm32_s = {instr_i[31:12], 12'h000};
         end
         OPC_SYSTEM: begin
            imm32_s = {{20{instr_i[31]}}, instr_i[31:20]};
            case (funct3_s)
               3'b001: begin
                  itype_s = ITYPE_CSR;
                  op_s    = INSTR_CSRRW;
               end
               3'b010: begin
                  itype_s = ITYPE_CSR;
                  op_s    = INSTR_CSRRS;
               end
               3'b011: begin
                  itype_s = ITYPE_CSR;
                  op_s    = INSTR_CSRRC;
               end
               default: begin
                  itype_s = ITYPE_ILL;
               end
            endcase
         end
         default: begin
            itype_s = ITYPE_ILL;
         end
      endcase
   end

   // Assemble the record; illegal words carry raw fields but no operation or immediate.
   always_comb begin
      fields_o.opcode  = opcode_s;
      fields_o.funct7  = funct7_s;
      fields_o.funct3  = funct3_s;
      fields_o.rs1     = instr_i[19:15];
      fields_o.rs2     = instr_i[24:20];
      fields_o.rd      = instr_i[11:7];
      fields_o.shamt   = instr_i[24:20];
      fields_o.csr     = instr_i[31:20];
      fields_o.itype   = itype_s;
      fields_o.instr   = op_s;
      fields_o.illegal = 1'b0;
      imm_o            = XLEN'(imm32_s);
      if (itype_s == ITYPE_ILL) begin
         fields_o.instr   = INSTR_AND;
         fields_o.illegal = 1'b1;
         imm_o            = {XLEN{1'b0}};
      end else begin
         fields_o.illegal = 1'b0;
      end
   end

endmodule

// File: rtl/rv_decode_queue.sv
// Registered RV32I decode stage: decoder feeding a DEPTH-entry FIFO, plus a
// saturating illegal-instruction counter and a pipeline flush.
module rv_decode_queue
   import rv_decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   rv_decode_queue_if.slave    q_if,
   output logic [CNT_W-1:0]    illegal_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef struct packed {
      decoded_fields_t f;
      logic [XLEN-1:0] imm;
   } decoded_t;

   decoded_fields_t dec_fields_s;
   logic [XLEN-1:0] dec_imm_s;
   decoded_t        dec_s;
   decoded_t        head_s;

   decoded_t        mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic full_s;
   logic empty_s;
   logic push_s;
   logic pop_s;

   rv_decode_comb #(.XLEN(XLEN)) u_dec (
      .instr_i  (q_if.in_instr),
      .fields_o (dec_fields_s),
      .imm_o    (dec_imm_s)
   );

   assign dec_s.f   = dec_fields_s;
   assign dec_s.imm = dec_imm_s;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_s = (wr_ptr_q == rd_ptr_q);

   // A flush wins over both directions; the input seen alongside it is lost.
   assign push_s = q_if.in_valid && !full_s && !flush;
   assign pop_s  = !empty_s && q_if.out_ready && !flush;

   // Next pointer and counter values.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end
      // Counts accepted illegal words; a flushed word was never accepted.
      if (push_s && dec_s.f.illegal && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Pointer and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // FIFO storage; cleared on reset so the head outputs read as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= dec_s;
      end else begin
         mem_q[wr_ptr_q[AW-1:0]] <= mem_q[wr_ptr_q[AW-1:0]];
      end
   end

   assign head_s = mem_q[rd_ptr_q[AW-1:0]];

   assign q_if.in_ready  = !full_s;
   assign q_if.out_valid = !empty_s;
   assign q_if.opcode    = head_s.f.opcode;
   assign q_if.funct7    = head_s.f.funct7;
   assign q_if.funct3    = head_s.f.funct3;
   assign q_if.rs1       = head_s.f.rs1;
   assign q_if.rs2       = head_s.f.rs2;
   assign q_if.rd        = head_s.f.rd;
   assign q_if.shamt     = head_s.f.shamt;
   assign q_if.csr       = head_s.f.csr;
   assign q_if.itype     = head_s.f.itype;
   assign q_if.instr     = head_s.f.instr;
   assign q_if.imm       = head_s.imm;
   assign q_if.illegal   = head_s.f.illegal;
   assign illegal_cnt    = cnt_q;

endmodule

// File: tb/tb_rv_decode_queue.sv
// Scoreboard bench for rv_decode_queue (XLEN=64, DEPTH=4, CNT_W=2).
module tb_rv_decode_queue;
   import rv_decode_pkg::*;

   localparam int XLEN  = 64;
   localparam int DEPTH = 4;
   localparam int CNT_W = 2;
   localparam int NV    = 19;
   localparam int CMAX  = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic [CNT_W-1:0] illegal_cnt;

   rv_decode_queue_if #(.XLEN(XLEN)) q_if ();

   rv_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .q_if        (q_if),
      .illegal_cnt (illegal_cnt)
   );

   always #5 clk = ~clk;

   // Hand-decoded vectors: word, itype, instr, imm, illegal.
   logic [31:0] vw [NV] = '{
      32'h00208033, 32'h40718433, 32'hFFF00293, 32'h123450B7, 32'h40209033,
      32'h4020D1B3, 32'h40325213, 32'hFFB13093, 32'h300322F3, 32'hFC009073,
      32'h00000073, 32'h023100B3, 32'h0083E333, 32'h41F09093, 32'h80000FB7,
      32'h0041D133, 32'h00103073, 32'h7FF0F093, 32'h00002083};
   logic [2:0] vt [NV] = '{
      3'd0, 3'd0, 3'd1, 3'd2, 3'd7, 3'd0, 3'd1, 3'd1, 3'd3, 3'd3,
      3'd7, 3'd7, 3'd0, 3'd7, 3'd2, 3'd0, 3'd3, 3'd1, 3'd7};
   logic [3:0] vo [NV] = '{
      4'h3, 4'h4, 4'h3, 4'hA, 4'h0, 4'h7, 4'h7, 4'h9, 4'hC, 4'hB,
      4'h0, 4'h0, 4'h1, 4'h0, 4'hA, 4'h6, 4'hD, 4'h0, 4'h0};
   logic [63:0] vi [NV] = '{
      64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_1234_5000, 64'h0,
      64'h0, 64'h403, 64'hFFFF_FFFF_FFFF_FFFB, 64'h300, 64'hFFFF_FFFF_FFFF_FFC0,
      64'h0, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_8000_0000,
      64'h0, 64'h1, 64'h7FF, 64'h0};
   logic vl [NV] = '{
      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
      1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int occ   = 0;
   int cnt_m = 0;
   bit done  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle of stimulus; the occupancy/counter model advances on the edge.
   task automatic step(input logic v, input int idx, input logic rdy, input logic fl,
                       output logic took);
      logic acc;
      logic popm;
      q_if.in_valid  = v;
      q_if.in_instr  = vw[idx];
      q_if.out_ready = rdy;
      flush          = fl;
      @(negedge clk);
      check("in_ready", 64'(q_if.in_ready), 64'(occ < DEPTH));
      check("out_valid", 64'(q_if.out_valid), 64'(occ != 0));
      check("illegal_cnt", 64'(illegal_cnt), 64'(cnt_m));
      took = v && (occ < DEPTH);
      acc  = took && !fl;
      popm = (occ != 0) && rdy && !fl;
      @(posedge clk);
      if (fl) begin
         occ = 0;
         exp_q.delete();
      end else begin
         if (acc) begin
            exp_q.push_back(idx);
            if (vl[idx] && (cnt_m < CMAX)) cnt_m++;
         end
         occ = occ + int'(acc) - int'(popm);
      end
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      flush          = 1'b0;
      q_if.in_valid  = 1'b0;
      q_if.in_instr  = 32'h0;
      q_if.out_ready = 1'b0;
      occ   = 0;
      cnt_m = 0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Monitor: compare every entry the DUT hands over against the scoreboard.
   initial begin
      int idx;
      logic [31:0] w;
      while (!done) begin
         @(negedge clk);
         if (!rst && q_if.out_valid && q_if.out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               check("spurious_out_valid", 64'(q_if.out_valid), 64'(0));
            end else begin
               idx = exp_q.pop_front();
               w   = vw[idx];
               check("opcode", 64'(q_if.opcode), 64'(w[6:0]));
               check("funct7", 64'(q_if.funct7), 64'(w[31:25]));
               check("funct3", 64'(q_if.funct3), 64'(w[14:12]));
               check("rs1", 64'(q_if.rs1), 64'(w[19:15]));
               check("rs2", 64'(q_if.rs2), 64'(w[24:20]));
               check("rd", 64'(q_if.rd), 64'(w[11:7]));
               check("shamt", 64'(q_if.shamt), 64'(w[24:20]));
               check("csr", 64'(q_if.csr), 64'(w[31:20]));
               check("itype", 64'(q_if.itype), 64'(vt[idx]));
               check("instr", 64'(q_if.instr), 64'(vo[idx]));
               check("imm", q_if.imm, vi[idx]);
               check("illegal", 64'(q_if.illegal), 64'(vl[idx]));
            end
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Stimulus sequence.
   initial begin
      logic t;
      logic v;
      logic rdy;
      logic fl;
      logic hold;
      int   idx;
      int   n;

      do_reset();
      @(negedge clk);
      check("rst_out_valid", 64'(q_if.out_valid), 64'(0));
      check("rst_in_ready", 64'(q_if.in_ready), 64'(1));
      check("rst_illegal_cnt", 64'(illegal_cnt), 64'(0));
      check("rst_opcode", 64'(q_if.opcode), 64'(0));
      check("rst_imm", q_if.imm, 64'(0));
      @(posedge clk);
      #1;

      // Back-to-back directed stream at full throughput.
      for (int i = 0; i < NV; i++) step(1'b1, i, 1'b1, 1'b0, t);
      repeat (3) step(1'b0, 0, 1'b1, 1'b0, t);

      // Backpressure: four fill the FIFO, the fifth is held until space frees.
      for (int k = 0; k < DEPTH; k++) step(1'b1, k, 1'b0, 1'b0, t);
      repeat (2) step(1'b1, 4, 1'b0, 1'b0, t);
      n = 0;
      do begin
         step(1'b1, 4, 1'b1, 1'b0, t);
         n++;
      end while (!t && (n < 10));
      if (!t) begin
         total++;
         bad++;
         $display("FAIL held_word_entry: got not accepted expected accepted");
      end
      repeat (6) step(1'b0, 0, 1'b1, 1'b0, t);

      // Flush with a concurrent push: everything, including the new word, is gone.
      for (int k = 0; k < 3; k++) step(1'b1, k + 5, 1'b0, 1'b0, t);
      step(1'b1, 8, 1'b0, 1'b1, t);
      repeat (2) step(1'b0, 0, 1'b1, 1'b0, t);

      // Random traffic drawn from the vector table.
      hold = 1'b0;
      v    = 1'b0;
      idx  = 0;
      for (int c = 0; c < 1000; c++) begin
         if (!hold) begin
            v   = ($urandom_range(0, 3) != 0);
            idx = $urandom_range(0, NV - 1);
         end
         rdy = ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 49) == 0);
         step(v, idx, rdy, fl, t);
         hold = v && !t;
      end

      // Reset in the middle of traffic behaves like a fresh start.
      step(1'b1, 0, 1'b0, 1'b0, t);
      step(1'b1, 4, 1'b0, 1'b0, t);
      do_reset();
      repeat (2) step(1'b0, 0, 1'b1, 1'b0, t);
      step(1'b1, 13, 1'b1, 1'b0, t);
      repeat (6) step(1'b0, 0, 1'b1, 1'b0, t);

      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
